// File: rtl/conditional_adder_tree.sv
// -----------------------------------------------------------------------------
// conditional_adder_tree
//
// Pipelined signed adder tree over NUM_CHANNELS packed samples. Each channel is
// optionally included (add_select_i) and optionally subtracted (negate_i). The
// per-sample controls are captured together with the data, so every result uses
// the controls that arrived with its own sample.
//
// Pipeline (L = clog2(NUM_CHANNELS) + 2 cycles from valid_i to valid_o):
//   stage 0   : capture data_i / add_select_i / negate_i when valid_i = 1
//   levels    : one register per binary-tree level; the channel count is
//               zero-padded up to the next power of two
//   output    : range-reduce to OUTPUT_WIDTH and register
//
// Internal arithmetic runs at FW = INPUT_WIDTH + clog2(NUM_CHANNELS) + 1 bits,
// which holds the worst case, including negation of the most negative sample.
//
// Build option:
//   CONDITIONAL_ADDER_SATURATE_EN  defined   -> out-of-range results clamp and
//                                               set the sticky overflow_o
//                                  undefined -> results wrap to OUTPUT_WIDTH
//                                               LSBs, overflow_o tied to 0
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_i         synchronous active-high reset
//   valid_i       data_i / add_select_i / negate_i valid this cycle
//   add_select_i  bit k includes channel k in the sum
//   negate_i      bit k subtracts channel k instead of adding it
//   data_i        packed signed samples, channel k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//   clear_ovf_i   clears overflow_o (a coincident new overflow wins)
//   data_o        signed registered sum, held while valid_o = 0
//   valid_o       one-cycle strobe per accepted sample, in input order
//   overflow_o    sticky: some result exceeded the OUTPUT_WIDTH signed range
// -----------------------------------------------------------------------------
module conditional_adder_tree #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned INPUT_WIDTH  = 14,
    parameter int unsigned OUTPUT_WIDTH = INPUT_WIDTH + 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                valid_i,
    input  logic [NUM_CHANNELS-1:0]             add_select_i,
    input  logic [NUM_CHANNELS-1:0]             negate_i,
    input  logic [NUM_CHANNELS*INPUT_WIDTH-1:0] data_i,
    input  logic                                clear_ovf_i,
    output logic signed [OUTPUT_WIDTH-1:0]      data_o,
    output logic                                valid_o,
    output logic                                overflow_o
);

    localparam int unsigned Levels    = $clog2(NUM_CHANNELS);
    localparam int unsigned Padded    = 1 << Levels;
    localparam int unsigned FullWidth = INPUT_WIDTH + Levels + 1;
    localparam int unsigned ExtBits   = FullWidth - INPUT_WIDTH;

    // -------------------------------------------------------------------------
    // Stage 0: capture a sample and its controls only when valid_i is high.
    // -------------------------------------------------------------------------
    logic [NUM_CHANNELS*INPUT_WIDTH-1:0] data_q;
    logic [NUM_CHANNELS-1:0]             sel_q;
    logic [NUM_CHANNELS-1:0]             neg_q;
    logic                                s0_vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= '0;
            sel_q    <= '0;
            neg_q    <= '0;
            s0_vld_q <= 1'b0;
        end else begin
            s0_vld_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
                sel_q  <= add_select_i;
                neg_q  <= negate_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel conditioned terms at full width; pad channels read as zero.
    // -------------------------------------------------------------------------
    logic signed [FullWidth-1:0] term [Padded];

    for (genvar k = 0; k < Padded; k++) begin : g_term
        if (k < NUM_CHANNELS) begin : g_real
            logic signed [INPUT_WIDTH-1:0] sample;
            logic signed [FullWidth-1:0]   sample_ext;

            assign sample     = $signed(data_q[k*INPUT_WIDTH +: INPUT_WIDTH]);
            // Extend before negating so -(-2^(W-1)) is representable.
            assign sample_ext = {{ExtBits{sample[INPUT_WIDTH-1]}}, sample};
            assign term[k]    = !sel_q[k] ? '0 :
                                neg_q[k]  ? -sample_ext : sample_ext;
        end else begin : g_pad
            assign term[k] = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Binary tree: level l holds Padded >> (l+1) registered partial sums.
    // Each level only loads when the level feeding it carries a valid sample.
    // -------------------------------------------------------------------------
    for (genvar l = 0; l < Levels; l++) begin : g_lvl
        localparam int unsigned Nodes = Padded >> (l + 1);

        logic signed [FullWidth-1:0] in_sum [2*Nodes];
        logic                        in_vld;
        logic signed [FullWidth-1:0] sum_q  [Nodes];
        logic                        vld_q;

        if (l == 0) begin : g_src
            assign in_sum = term;
            assign in_vld = s0_vld_q;
        end else begin : g_src
            assign in_sum = g_lvl[l-1].sum_q;
            assign in_vld = g_lvl[l-1].vld_q;
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_q <= 1'b0;
                for (int i = 0; i < Nodes; i++) begin
                    sum_q[i] <= '0;
                end
            end else begin
                vld_q <= in_vld;
                if (in_vld) begin
                    for (int i = 0; i < Nodes; i++) begin
                        sum_q[i] <= in_sum[2*i] + in_sum[2*i+1];
                    end
                end
            end
        end
    end

    logic signed [FullWidth-1:0] full_sum;
    logic                        full_vld;

    assign full_sum = g_lvl[Levels-1].sum_q[0];
    assign full_vld = g_lvl[Levels-1].vld_q;

    // -------------------------------------------------------------------------
    // Output range reduction.
    // -------------------------------------------------------------------------
    logic signed [OUTPUT_WIDTH-1:0] result_d;
    logic                           ovf_d;
    logic signed [OUTPUT_WIDTH-1:0] result_q;
    logic                           vld_out_q;
    logic                           ovf_q;

`ifdef CONDITIONAL_ADDER_SATURATE_EN
    localparam logic signed [FullWidth-1:0] MaxOut =
        {{(FullWidth-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [FullWidth-1:0] MinOut =
        {{(FullWidth-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    logic too_high;
    logic too_low;

    assign too_high = full_sum > MaxOut;
    assign too_low  = full_sum < MinOut;

    always_comb begin
        result_d = full_sum[OUTPUT_WIDTH-1:0];
        if (too_high) begin
            result_d = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        end else if (too_low) begin
            result_d = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        end
    end

    // A new overflow takes priority over a coincident clear.
    always_comb begin
        ovf_d = ovf_q;
        if (full_vld && (too_high || too_low)) begin
            ovf_d = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end
    end
`else
    logic unused_bits;

    // Plain two's-complement wrap; the flag and its clear have no effect.
    assign result_d    = full_sum[OUTPUT_WIDTH-1:0];
    assign ovf_d       = 1'b0;
    assign unused_bits = ^{clear_ovf_i, full_sum};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q  <= '0;
            vld_out_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            vld_out_q <= full_vld;
            ovf_q     <= ovf_d;
            if (full_vld) begin
                result_q <= result_d;
            end
        end
    end

    assign data_o     = result_q;
    assign valid_o    = vld_out_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_conditional_adder_tree.sv
module tb_conditional_adder_tree;

    localparam int Lat = 4;

    logic               clk = 1'b0;
    logic               rst_i;
    logic               valid_i;
    logic [3:0]         add_select_i;
    logic [3:0]         negate_i;
    logic [55:0]        data_i;
    logic               clear_ovf_i;
    logic signed [15:0] data_o;
    logic               valid_o;
    logic               overflow_o;

    conditional_adder_tree dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .add_select_i (add_select_i),
        .negate_i     (negate_i),
        .data_i       (data_i),
        .clear_ovf_i  (clear_ovf_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic [3:0] neg;
        int         d0;
        int         d1;
        int         d2;
        int         d3;
        int         sum;   // full-precision expected sum
    } vec_t;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   cyc    = 0;
    int   nvalid = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int map_out(input int full);
`ifdef CONDITIONAL_ADDER_SATURATE_EN
        if (full > 32767) return 32767;
        if (full < -32768) return -32768;
        return full;
`else
        logic [15:0] t;
        t = full[15:0];
        return int'($signed(t));
`endif
    endfunction

    function automatic int exp_ovf(input int full);
`ifdef CONDITIONAL_ADDER_SATURATE_EN
        return (full > 32767 || full < -32768) ? 1 : 0;
`else
        return (full == full + 1) ? 1 : 0;
`endif
    endfunction

    // Scoreboard consumer: every valid_o must match the oldest outstanding
    // sample, arriving exactly Lat cycles after that sample was presented.
    always @(negedge clk) begin
        if (valid_o) begin
            exp_t e;
            nvalid++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_valid: got valid_o=1 data_o=%0d, expected no output (cycle %0d)",
                         data_o, cyc);
            end else begin
                e = sb.pop_front();
                check("data", int'(data_o), e.data);
                check("latency", cyc - e.cyc, Lat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        step();
    endtask

    task automatic drive(input logic [3:0] sel, input logic [3:0] neg,
                         input int d0, input int d1, input int d2, input int d3,
                         input int full);
        exp_t e;
        valid_i      = 1'b1;
        add_select_i = sel;
        negate_i     = neg;
        data_i       = {d3[13:0], d2[13:0], d1[13:0], d0[13:0]};
        e.data       = map_out(full);
        e.cyc        = cyc;
        sb.push_back(e);
        step();
    endtask

    initial begin
        int nv0;

        tbl[0]  = '{4'b1111, 4'b0000,   100,   100,   100,   100,    400};
        tbl[1]  = '{4'b0011, 4'b0010,  1000,   300,  5000,  5000,    700};
        tbl[2]  = '{4'b0000, 4'b0000,  1234,  1234,  1234,  1234,      0};
        tbl[3]  = '{4'b1111, 4'b1111, -8192, -8192, -8192, -8192,  32768};
        tbl[4]  = '{4'b0101, 4'b0001, -8192,     7,  8191,     1,  16383};
        tbl[5]  = '{4'b1111, 4'b0000,  8191,  8191,  8191,  8191,  32764};
        tbl[6]  = '{4'b1010, 4'b1000,   333,    -5,   444,    20,    -25};
        tbl[7]  = '{4'b1001, 4'b0000, -8192,    11,    22, -8192, -16384};
        tbl[8]  = '{4'b1111, 4'b1111,  8191,  8191,  8191,  8191, -32764};
        tbl[9]  = '{4'b1111, 4'b0001, -8192,  8191,  8191,  8191,  32765};
        tbl[10] = '{4'b1111, 4'b0000, -8192, -8192, -8192, -8192, -32768};
        tbl[11] = '{4'b1110, 4'b0000,  8191,  8191,  8191,  8191,  24573};

        rst_i        = 1'b1;
        valid_i      = 1'b0;
        add_select_i = '0;
        negate_i     = '0;
        data_i       = '0;
        clear_ovf_i  = 1'b0;
        repeat (3) step();
        check("reset_data_o", int'(data_o), 0);
        check("reset_valid_o", int'(valid_o), 0);
        check("reset_overflow_o", int'(overflow_o), 0);
        rst_i = 1'b0;
        step();

        // Single pulse: one result, exactly one valid_o cycle.
        nv0 = nvalid;
        drive(4'b1111, 4'b0000, 100, 100, 100, 100, 400);
        repeat (8) idle();
        check("pulse_valid_count", nvalid - nv0, 1);

        // Table vectors back to back at full throughput.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].sel, tbl[i].neg, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].d3,
                  tbl[i].sum);
        end
        repeat (8) idle();
        check("table_drained", sb.size(), 0);

        // data_o holds the last result while idle.
        for (int i = 0; i < 3; i++) begin
            check("hold_data_o", int'(data_o), map_out(tbl[11].sum));
            check("hold_valid_o", int'(valid_o), 0);
            idle();
        end

        // Streaming: channel 0 only, 1..8 on consecutive cycles.
        nv0 = nvalid;
        for (int i = 1; i <= 8; i++) begin
            drive(4'b0001, 4'b0000, i, 777, -777, 4000, i);
        end
        repeat (8) idle();
        check("stream_valid_count", nvalid - nv0, 8);

        // Overflow flag: clear, set, sticky, clear again.
        clear_ovf_i = 1'b1;
        step();
        clear_ovf_i = 1'b0;
        step();
        check("ovf_cleared", int'(overflow_o), 0);
        drive(4'b1111, 4'b1111, -8192, -8192, -8192, -8192, 32768);
        repeat (6) idle();
        check("ovf_set", int'(overflow_o), exp_ovf(32768));
        repeat (3) idle();
        check("ovf_sticky", int'(overflow_o), exp_ovf(32768));
        clear_ovf_i = 1'b1;
        step();
        clear_ovf_i = 1'b0;
        check("ovf_clear_after", int'(overflow_o), 0);

        // Clear coincident with the edge that registers a new overflow.
        drive(4'b1111, 4'b1111, -8192, -8192, -8192, -8192, 32768);
        idle();
        idle();
        clear_ovf_i = 1'b1;
        step();
        clear_ovf_i = 1'b0;
        check("ovf_set_beats_clear", int'(overflow_o), exp_ovf(32768));
        repeat (4) idle();

        // Reset mid-flight: sample at cycle 0, reset at cycle 2 with valid_i
        // also high; neither sample may emerge.
        nv0 = nvalid;
        valid_i      = 1'b1;
        add_select_i = 4'b0001;
        negate_i     = 4'b0000;
        data_i       = 56'd50;
        step();
        idle();
        rst_i   = 1'b1;
        valid_i = 1'b1;
        step();
        rst_i   = 1'b0;
        valid_i = 1'b0;
        repeat (8) idle();
        check("midreset_no_valid", nvalid - nv0, 0);
        check("midreset_data_o", int'(data_o), 0);
        check("midreset_overflow_o", int'(overflow_o), 0);

        // First sample after reset is accepted normally.
        drive(4'b0011, 4'b0010, 1000, 300, 5000, 5000, 700);
        repeat (8) idle();
        check("final_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
